// File: rtl/serial_frame_rx_if.sv
// Serial input strobe and parallel result bundle for serial_frame_rx.
// ParErr exists only when SERIAL_FRAME_RX_PARITY_CHECK_EN is defined.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              Di;
    logic              BitEn;
    logic [DATA_W-1:0] Dout;
    logic              Valid;
    logic              FrameErr;
    logic              Busy;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
    logic              ParErr;
`endif

    modport master (
        output Di,
        output BitEn,
        input  Dout,
        input  Valid,
        input  FrameErr,
        input  Busy
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        ,
        input  ParErr
`endif
    );

    modport slave (
        input  Di,
        input  BitEn,
        output Dout,
        output Valid,
        output FrameErr,
        output Busy
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        ,
        output ParErr
`endif
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start(0), DATA_W data bits LSB first, optional even parity, stop(1).
// Define SERIAL_FRAME_RX_PARITY_CHECK_EN to add the parity bit, PARITY state and ParErr output.
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input logic              Clk,
    input logic              Resetn,
    serial_frame_rx_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_STOP   = 3'd2,
        ST_BREAK  = 3'd3
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        ,
        ST_PARITY = 3'd4
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;
    logic              par_bad_s;

`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;

    function automatic logic even_parity_err(input logic [DATA_W-1:0] data, input logic par);
        return (^data) ^ par;
    endfunction

    assign par_bad_s = even_parity_err(shift_q, par_q);
`else
    assign par_bad_s = 1'b0;
`endif

    // Next-state, datapath and pulse decode; everything advances only on strobed edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (bus.BitEn) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.Di) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d             = shift_q >> 1;
                    shift_d[DATA_W-1]   = bus.Di;
                    cnt_d               = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
                ST_PARITY: begin
                    par_d   = bus.Di;
                    state_d = ST_STOP;
                end
`endif
                ST_STOP: begin
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
                    perr_d = par_bad_s;
`endif
                    if (bus.Di) begin
                        state_d = ST_IDLE;
                        if (!par_bad_s) begin
                            valid_d = 1'b1;
                            dout_d  = shift_q;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
                // A held-low line must return high before a new start bit counts.
                ST_BREAK: begin
                    if (bus.Di) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.Dout     = dout_q;
    assign bus.Valid    = valid_q;
    assign bus.FrameErr = ferr_q;
    assign bus.Busy     = busy_q;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
    assign bus.ParErr   = perr_q;
`endif
endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frame table, hand sequences, random frames vs model.
module tb_serial_frame_rx;
    localparam int DATA_W = 8;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_LEN = DATA_W + 2 + (PAR_EN ? 1 : 0);

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              stop;
        logic              parbad;
        int                gap;
        int                hold;
        logic              exp_valid;
        logic              exp_ferr;
        logic              exp_perr;
        logic [DATA_W-1:0] exp_dout;
        logic              exp_busy;
    } vec_t;

    logic              clk = 1'b0;
    logic              resetn;
    int                n_checks = 0;
    int                n_pass = 0;
    int                strobe_cnt = 0;
    logic              stray;
    logic              s_valid, s_ferr, s_perr, s_busy;
    logic [DATA_W-1:0] s_dout;
    logic [DATA_W-1:0] model_dout;

    serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_rx #(.DATA_W(DATA_W)) dut (
        .Clk    (clk),
        .Resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic sample_outputs();
        s_valid = bus.Valid;
        s_ferr  = bus.FrameErr;
        s_busy  = bus.Busy;
        s_dout  = bus.Dout;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        s_perr  = bus.ParErr;
`else
        s_perr  = 1'b0;
`endif
    endtask

    // One strobed bit, then `gap` unstrobed cycles with Di scrambled; pulses must be gone by then.
    task automatic send_bit(input logic b, input int gap);
        bus.Di    = b;
        bus.BitEn = 1'b1;
        @(posedge clk);
        #1;
        strobe_cnt++;
        sample_outputs();
        bus.BitEn = 1'b0;
        for (int i = 0; i < gap; i++) begin
            bus.Di = 1'($urandom);
            @(posedge clk);
            #1;
            if (bus.Valid || bus.FrameErr || bus.Dout !== s_dout) stray = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop,
                              input logic parbad, input int gap);
        send_bit(1'b0, gap);
        stray = stray | s_valid | s_ferr;
        for (int i = 0; i < DATA_W; i++) begin
            send_bit(data[i], gap);
            stray = stray | s_valid | s_ferr;
        end
        if (PAR_EN) begin
            send_bit((^data) ^ parbad, gap);
            stray = stray | s_valid | s_ferr;
        end
        send_bit(stop, 0);
        sample_outputs();
        for (int i = 0; i < gap; i++) begin
            bus.BitEn = 1'b0;
            bus.Di    = 1'($urandom);
            @(posedge clk);
            #1;
            if (bus.Valid || bus.FrameErr) stray = 1'b1;
        end
    endtask

    // Frame-level expectation: a frame is delivered only with a good stop and good parity.
    function automatic vec_t model_frame(input logic [DATA_W-1:0] data, input logic stop,
                                         input logic parbad, input int gap, input int hold);
        vec_t v;
        logic good;
        good        = stop && !(PAR_EN && parbad);
        v.data      = data;
        v.stop      = stop;
        v.parbad    = parbad;
        v.gap       = gap;
        v.hold      = hold;
        v.exp_valid = good;
        v.exp_ferr  = !stop;
        v.exp_perr  = PAR_EN && parbad;
        v.exp_dout  = good ? data : model_dout;
        v.exp_busy  = !stop;
        return v;
    endfunction

    function automatic vec_t mk(input logic [DATA_W-1:0] data, input logic stop, input logic parbad,
                                input int gap, input int hold, input logic ev, input logic ef,
                                input logic ep, input logic [DATA_W-1:0] ed, input logic eb);
        vec_t v;
        v.data = data; v.stop = stop; v.parbad = parbad; v.gap = gap; v.hold = hold;
        v.exp_valid = ev; v.exp_ferr = ef; v.exp_perr = ep; v.exp_dout = ed; v.exp_busy = eb;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        stray = 1'b0;
        send_frame(v.data, v.stop, v.parbad, v.gap);
        chk({tag, ".valid"}, 32'(s_valid), 32'(v.exp_valid));
        chk({tag, ".frameerr"}, 32'(s_ferr), 32'(v.exp_ferr));
        chk({tag, ".dout"}, 32'(s_dout), 32'(v.exp_dout));
        chk({tag, ".busy"}, 32'(s_busy), 32'(v.exp_busy));
        if (PAR_EN) chk({tag, ".parerr"}, 32'(s_perr), 32'(v.exp_perr));
        chk({tag, ".no_stray_pulse"}, 32'(stray), 32'd0);
        model_dout = v.exp_dout;
        if (!v.stop) begin
            stray = 1'b0;
            for (int i = 0; i < v.hold; i++) begin
                send_bit(1'b0, v.gap);
                stray = stray | s_valid | s_ferr | !s_busy;
            end
            chk({tag, ".break_held"}, 32'(stray), 32'd0);
            send_bit(1'b1, v.gap);
            chk({tag, ".break_release_busy"}, 32'(s_busy), 32'd0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int t1, t2;
        vecs[0] = mk(8'hA5, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        vecs[1] = mk(8'hA5, 1'b1, 1'b0, 3, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        vecs[2] = mk(8'h0F, 1'b0, 1'b0, 0, 5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1);
        vecs[3] = mk(8'h01, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
        vecs[4] = mk(8'h03, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0);
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        vecs[5] = mk(8'h03, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
        vecs[6] = mk(8'h5A, 1'b0, 1'b1, 0, 2, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1);
`else
        vecs[5] = mk(8'h03, 1'b1, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0);
        vecs[6] = mk(8'h5A, 1'b0, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1);
`endif

        resetn    = 1'b0;
        bus.Di    = 1'b1;
        bus.BitEn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample_outputs();
        chk("reset.dout", 32'(s_dout), 32'd0);
        chk("reset.valid", 32'(s_valid), 32'd0);
        chk("reset.frameerr", 32'(s_ferr), 32'd0);
        chk("reset.busy", 32'(s_busy), 32'd0);
        resetn     = 1'b1;
        model_dout = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a frame discards the partial word.
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        resetn    = 1'b0;
        bus.Di    = 1'b0;
        bus.BitEn = 1'b1;
        @(posedge clk);
        #1;
        sample_outputs();
        chk("midreset.dout", 32'(s_dout), 32'd0);
        chk("midreset.valid", 32'(s_valid), 32'd0);
        chk("midreset.frameerr", 32'(s_ferr), 32'd0);
        chk("midreset.busy", 32'(s_busy), 32'd0);
        resetn     = 1'b1;
        bus.Di     = 1'b1;
        bus.BitEn  = 1'b0;
        model_dout = '0;
        @(posedge clk);
        #1;
        run_frame(model_frame(8'h3C, 1'b1, 1'b0, 0, 0), "after_reset");

        // Back-to-back frames, no idle bit: Valid pulses exactly one frame length apart.
        run_frame(model_frame(8'h01, 1'b1, 1'b0, 0, 0), "b2b_first");
        t1 = strobe_cnt;
        run_frame(model_frame(8'hFF, 1'b1, 1'b0, 0, 0), "b2b_second");
        t2 = strobe_cnt;
        chk("b2b.strobe_distance", 32'(t2 - t1), 32'(FRAME_LEN));

        for (int i = 0; i < 40; i++) begin
            logic [DATA_W-1:0] d;
            logic              st, pb;
            d  = DATA_W'($urandom);
            st = ($urandom_range(0, 4) != 0);
            pb = ($urandom_range(0, 4) == 0);
            run_frame(model_frame(d, st, pb, $urandom_range(0, 3), $urandom_range(0, 4)),
                      $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Bit-serial frame receiver for the Lab3 storage-element exercises; it is the receiving end of the serial Di stream that the lab benches drive.
- Samples Di on Clk edges qualified by a bit strobe and detects a start bit.
- Shifts in DATA_W data bits, LSB first, and checks the stop bit.
- Presents a parallel word with a one-cycle valid pulse and flags framing errors.
- Sits between a DE2-115 switch/GPIO serial input and the display/LED logic.

Parameters:
- DATA_W, 8, data bits per frame; legal range 1..16.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Resetn  input  1  synchronous, active-low reset, sampled on rising Clk.
- Di  input  1  serial data line; idle level 1.
- BitEn  input  1  bit strobe; Di is sampled only on edges where BitEn=1.
- Dout  output  DATA_W  last good received word.
- Valid  output  1  one-cycle pulse: Dout just updated.
- FrameErr  output  1  one-cycle pulse: stop bit sampled as 0.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (Resetn=0 at a rising edge) forces the following, regardless of state or mid-frame position:
  - Dout=0, Valid=0, FrameErr=0, Busy=0.
  - State=IDLE, bit counter=0, shift register=0.
- Frame format: start(0), DATA_W data bits LSB first, [parity if PARITY_CHECK_EN], stop(1).
- State machine (all transitions occur only on edges with BitEn=1; with BitEn=0 the state holds and Valid/FrameErr drop to 0):
  - IDLE: Di=0 -> DATA, counter=0. Di=1 -> stay.
  - DATA: shift Di into MSB of the shift register (right shift), counter+1. When counter reaches DATA_W-1 on this edge -> PARITY if enabled, else STOP.
  - PARITY (feature only): capture the parity bit -> STOP.
  - STOP, Di=1 and no parity error: Dout<=shift register, Valid<=1 -> IDLE.
  - STOP, Di=0: FrameErr<=1, Dout unchanged -> BREAK.
  - BREAK: wait for Di=1 -> IDLE. Prevents a held-low line from being taken as back-to-back start bits.
- Pulse timing:
  - Valid and FrameErr are registered.
  - Each is high for exactly the one Clk cycle after the stop-sampling edge, independent of BitEn in that next cycle.
- Latency: Valid rises 1 Clk after the edge that samples the stop bit.
- Dout holds its value until the next good frame; it is never partially updated.
- Busy is a registered decode of state != IDLE.
- Counter width is $clog2(DATA_W)+1 and never wraps within a frame.
- A start bit is recognised on the very edge after a STOP->IDLE transition, so back-to-back frames with no idle bit are accepted.
- Glitch rejection of the start bit is not performed; a single 0 sample starts a frame.
- Resetn deasserted mid-frame: the partially received word is discarded, and no Valid or FrameErr is produced for it.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_CHECK_EN.
- Defined:
  - One even-parity bit follows the data bits.
  - The PARITY state and an extra output ParErr (1 bit) exist.
  - ParErr behaviour: if XOR(data bits, parity bit)=1 when the frame reaches STOP, ParErr pulses for one cycle alongside normal STOP handling. Valid is suppressed and Dout is unchanged; the state returns to IDLE if stop=1.
  - Stop=0 with bad parity: FrameErr and ParErr both pulse.
- Undefined: no PARITY state, no ParErr port, and the frame is DATA_W+2 bits.

Test Plan:
- Reset mid-frame: send start plus 3 bits of 0xA5 with BitEn=1, assert Resetn=0 for one edge -> Dout=0x00, Valid=0, Busy=0; the following full frame 0x3C gives Dout=0x3C.
- Good frame: BitEn=1 every cycle, Di=0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first, stop 1) -> Valid high exactly one cycle after the stop edge, Dout=0xA5, Busy falls with it.
- Strobe gating: same 0xA5 frame with BitEn=1 every 4th cycle and Di changing only on strobe cycles -> identical result; Di toggling on non-strobe cycles has no effect.
- Framing error: frame 0x0F with stop bit 0, then Di held 0 for 5 strobes, then Di=1 -> FrameErr one pulse, Dout keeps its previous 0xA5, no new frame starts until Di=1 is sampled.
- Back-to-back: frames 0x01 and 0xFF with no idle bit between -> two Valid pulses exactly 10 strobes apart, Dout=0x01 then 0xFF.
- Parity (macro defined): 0x03 with parity 0 -> Valid, Dout=0x03. 0x03 with parity 1 -> ParErr pulse, no Valid, Dout unchanged.
